// File: rtl/i2c_pkg.sv
// Shared I2C definitions: instruction codes of the 2-bit master interface
// and the bus-arbiter state encoding.
package i2c_pkg;

  localparam logic [1:0] INST_START_TX   = 2'd0;
  localparam logic [1:0] INST_STOP_TX    = 2'd1;
  localparam logic [1:0] INST_READ_BYTE  = 2'd2;
  localparam logic [1:0] INST_WRITE_BYTE = 2'd3;

  typedef enum logic [1:0] {
    ARB,
    OWNED,
    FORCE_STOP,
    FORCE_WAIT
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req_i strictly after
// last_i, circularly. Ports: req_i, last_i in; valid_o, idx_o out.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  int            sum;
  logic [IW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = last_i;
    sum     = 0;
    cand    = '0;
    // i = N wraps back to last_i itself, so it has lowest priority
    for (int i = 1; i <= N; i++) begin
      sum = int'(last_i) + i;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master among NUM_REQ requesters, one whole START..STOP
// transaction at a time, round-robin, with a watchdog that forces a STOP.
// Ports: req_* per-requester side; i2c_* master side; grant_o/busy_o/
// timeout_o status.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 270000,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_enable_i,
  input  logic [2*NUM_REQ-1:0]   req_instruction_i,
  input  logic [8*NUM_REQ-1:0]   req_byte_to_send_i,
  output logic [NUM_REQ-1:0]     req_complete_o,
  output logic [7:0]             req_byte_received_o,
  output logic [1:0]             i2c_instruction_o,
  output logic                   i2c_enable_o,
  output logic [7:0]             i2c_byte_to_send_o,
  input  logic [7:0]             i2c_byte_received_i,
  input  logic                   i2c_complete_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 stop_q, stop_d;
  logic                 started_q, started_d;
  logic                 en_q, en_d;
  logic [1:0]           inst_q, inst_d;
  logic [7:0]           byte_q, byte_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;

  logic                 own_en, pk_en;
  logic [1:0]           own_inst, pk_inst;
  logic [7:0]           own_byte, pk_byte;

  always_comb begin
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand[k] = req_enable_i[k] &
                (req_instruction_i[2*k +: 2] == INST_START_TX);
    end
  end

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (cand),
    .last_i  (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // rr_q doubles as the owner index while the bus is held
  always_comb begin
    own_en   = 1'b0;
    own_inst = '0;
    own_byte = '0;
    pk_en    = 1'b0;
    pk_inst  = '0;
    pk_byte  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_q == IW'(k)) begin
        own_en   = req_enable_i[k];
        own_inst = req_instruction_i[2*k +: 2];
        own_byte = req_byte_to_send_i[8*k +: 8];
      end
      if (pick_idx == IW'(k)) begin
        pk_en   = req_enable_i[k];
        pk_inst = req_instruction_i[2*k +: 2];
        pk_byte = req_byte_to_send_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    wd_d      = wd_q;
    stop_d    = stop_q;
    started_d = started_q;
    en_d      = en_q;
    inst_d    = inst_q;
    byte_d    = byte_q;
    tmo_d     = 1'b0;
    unique case (state_q)
      ARB: begin
        en_d   = 1'b0;
        wd_d   = '0;
        stop_d = 1'b0;
        if (pick_valid) begin
          state_d           = OWNED;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          rr_d              = pick_idx;
          en_d              = pk_en;
          inst_d            = pk_inst;
          byte_d            = pk_byte;
        end
      end
      OWNED: begin
        en_d   = own_en;
        inst_d = own_inst;
        byte_d = own_byte;
        if (own_en && own_inst == INST_STOP_TX) stop_d = 1'b1;
        if (own_en) begin
          wd_d = '0;
        end else if (!stop_q) begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
        if (stop_q && !own_en && i2c_complete_i) begin
          grant_d = '0;
          en_d    = 1'b0;
          stop_d  = 1'b0;
          state_d = ARB;
        end else if (!own_en && !stop_q && wd_q == WD_LAST) begin
          grant_d = '0;
          wd_d    = '0;
          state_d = FORCE_STOP;
        end
      end
      FORCE_STOP: begin
        inst_d    = INST_STOP_TX;
        en_d      = 1'b1;
        started_d = 1'b0;
        state_d   = FORCE_WAIT;
      end
      FORCE_WAIT: begin
        // ignore a complete left over from the stalled owner's last op
        if (!started_q && !i2c_complete_i) started_d = 1'b1;
        if (started_q && i2c_complete_i) begin
          en_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB;
      grant_q   <= '0;
      rr_q      <= IW'(NUM_REQ - 1);
      wd_q      <= '0;
      stop_q    <= 1'b0;
      started_q <= 1'b0;
      en_q      <= 1'b0;
      inst_q    <= '0;
      byte_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      wd_q      <= wd_d;
      stop_q    <= stop_d;
      started_q <= started_d;
      en_q      <= en_d;
      inst_q    <= inst_d;
      byte_q    <= byte_d;
      tmo_q     <= tmo_d;
    end
  end

  assign req_complete_o      = {NUM_REQ{i2c_complete_i}} & grant_q;
  assign req_byte_received_o = i2c_byte_received_i;
  assign i2c_instruction_o   = inst_q;
  assign i2c_enable_o        = en_q;
  assign i2c_byte_to_send_o  = byte_q;
  assign grant_o             = grant_q;
  assign busy_o              = (state_q != ARB);
  assign timeout_o           = tmo_q;

endmodule
